// File: rtl/run_length_detector.sv
// run_length_detector: flags every run of RUN_LEN identical bits on a valid/ready serial stream.
// Optional accepted-detection counter is built only when RUN_DETECT_STATS_EN is defined.
module run_length_detector #(
  parameter int unsigned RUN_LEN = 2,
  parameter int unsigned OVERLAP = 0,
  parameter int unsigned CNT_W   = $clog2(RUN_LEN + 1),
  parameter int unsigned EVT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  output logic             det_valid,
  input  logic             det_ready,
  output logic             det_bit,
  output logic [CNT_W-1:0] run_cnt,
  output logic [1:0]       state_o,
  output logic [EVT_W-1:0] evt_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] RunLenC   = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] RunLenM1C = CNT_W'(RUN_LEN - 1);
  localparam logic [CNT_W-1:0] OneC      = CNT_W'(1);

  state_t           stateQ;
  logic             lastBit;
  logic             inAccept;
  logic             outAccept;
  logic [CNT_W-1:0] runNext;

  assign in_ready  = (stateQ != HOLD);
  assign inAccept  = in_valid && in_ready;
  assign outAccept = det_valid && det_ready;
  assign state_o   = stateQ;

  // run_cnt stays below RUN_LEN outside HOLD, so the increment cannot wrap
  assign runNext = run_cnt + OneC;

  // Run-tracking FSM; clear acts like reset and discards any same-cycle accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ    <= IDLE;
      run_cnt   <= '0;
      lastBit   <= 1'b0;
      det_valid <= 1'b0;
      det_bit   <= 1'b0;
    end else if (clear) begin
      stateQ    <= IDLE;
      run_cnt   <= '0;
      lastBit   <= 1'b0;
      det_valid <= 1'b0;
      det_bit   <= 1'b0;
    end else begin
      case (stateQ)
        IDLE: begin
          if (inAccept) begin
            stateQ  <= COUNT;
            run_cnt <= OneC;
            lastBit <= in_bit;
          end
        end
        COUNT: begin
          if (inAccept) begin
            if (in_bit == lastBit) begin
              if (runNext == RunLenC) begin
                stateQ    <= HOLD;
                run_cnt   <= RunLenC;
                det_valid <= 1'b1;
                det_bit   <= lastBit;
              end else begin
                run_cnt <= runNext;
              end
            end else begin
              run_cnt <= OneC;
              lastBit <= in_bit;
            end
          end
        end
        HOLD: begin
          if (det_ready) begin
            det_valid <= 1'b0;
            if (OVERLAP != 0) begin
              // keep the run one short of RUN_LEN so the next equal bit re-detects
              stateQ  <= COUNT;
              run_cnt <= RunLenM1C;
            end else begin
              stateQ  <= IDLE;
              run_cnt <= '0;
            end
          end
        end
        default: begin
          stateQ    <= IDLE;
          run_cnt   <= '0;
          lastBit   <= 1'b0;
          det_valid <= 1'b0;
          det_bit   <= 1'b0;
        end
      endcase
    end
  end

`ifdef RUN_DETECT_STATS_EN
  logic [EVT_W-1:0] evtQ;

  // Saturating count of detections taken by the consumer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evtQ <= '0;
    end else if (clear) begin
      evtQ <= '0;
    end else if (outAccept && (evtQ != {EVT_W{1'b1}})) begin
      evtQ <= evtQ + EVT_W'(1);
    end
  end

  assign evt_count = evtQ;
`else
  logic unusedAccept;
  assign unusedAccept = outAccept;
  assign evt_count    = '0;
`endif

endmodule

// File: tb/tb_run_length_detector.sv
// Scoreboard bench for run_length_detector: three instances cover non-overlap, overlap with a
// 2-bit saturating event counter, and run-length-3 non-overlap with back-pressure.
module tb_run_length_detector;

`ifdef RUN_DETECT_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  typedef struct {
    int   dut;
    logic b;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [2:0]      clear;
  logic [2:0]      inValid;
  logic [2:0]      inReady;
  logic [2:0]      inBit;
  logic [2:0]      detValid;
  logic [2:0]      detReady;
  logic [2:0]      detBit;
  logic [2:0][1:0] runCnt;
  logic [2:0][1:0] stateO;
  logic [15:0]     evtA;
  logic [1:0]      evtB;
  logic [15:0]     evtC;

  int   runLenOf  [3] = '{2, 3, 3};
  int   overlapOf [3] = '{0, 1, 0};
  int   modelCnt  [3];
  logic modelLast [3];
  int   nAcc      [3];
  exp_t expQ[$];
  int   nCompared   = 0;
  int   nMismatched = 0;

  always #5 clk = ~clk;

  run_length_detector #(.RUN_LEN(2), .OVERLAP(0), .EVT_W(16)) dutA (
    .clk(clk), .rst_n(rst_n), .clear(clear[0]), .in_valid(inValid[0]), .in_ready(inReady[0]),
    .in_bit(inBit[0]), .det_valid(detValid[0]), .det_ready(detReady[0]), .det_bit(detBit[0]),
    .run_cnt(runCnt[0]), .state_o(stateO[0]), .evt_count(evtA));

  run_length_detector #(.RUN_LEN(3), .OVERLAP(1), .EVT_W(2)) dutB (
    .clk(clk), .rst_n(rst_n), .clear(clear[1]), .in_valid(inValid[1]), .in_ready(inReady[1]),
    .in_bit(inBit[1]), .det_valid(detValid[1]), .det_ready(detReady[1]), .det_bit(detBit[1]),
    .run_cnt(runCnt[1]), .state_o(stateO[1]), .evt_count(evtB));

  run_length_detector #(.RUN_LEN(3), .OVERLAP(0), .EVT_W(16)) dutC (
    .clk(clk), .rst_n(rst_n), .clear(clear[2]), .in_valid(inValid[2]), .in_ready(inReady[2]),
    .in_bit(inBit[2]), .det_valid(detValid[2]), .det_ready(detReady[2]), .det_bit(detBit[2]),
    .run_cnt(runCnt[2]), .state_o(stateO[2]), .evt_count(evtC));

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int expEvt(input int d, input int maxV);
    if (!StatsEn) return 0;
    return (nAcc[d] > maxV) ? maxV : nAcc[d];
  endfunction

  task automatic resetModel();
    for (int d = 0; d < 3; d++) begin
      modelCnt[d]  = 0;
      modelLast[d] = 1'b0;
      nAcc[d]      = 0;
    end
    expQ.delete();
  endtask

  task automatic checkResetState(input string tag);
    for (int d = 0; d < 3; d++) begin
      checkEq($sformatf("%s_state%0d", tag, d), 32'(stateO[d]), 0);
      checkEq($sformatf("%s_runCnt%0d", tag, d), 32'(runCnt[d]), 0);
      checkEq($sformatf("%s_detValid%0d", tag, d), 32'(detValid[d]), 0);
      checkEq($sformatf("%s_detBit%0d", tag, d), 32'(detBit[d]), 0);
      checkEq($sformatf("%s_inReady%0d", tag, d), 32'(inReady[d]), 1);
    end
    checkEq($sformatf("%s_evtA", tag), 32'(evtA), 0);
    checkEq($sformatf("%s_evtB", tag), 32'(evtB), 0);
    checkEq($sformatf("%s_evtC", tag), 32'(evtC), 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one bit, wait (bounded) for it to be taken, then check against the model
  task automatic sendBit(input int d, input logic b);
    logic rdy;
    bit   det;
    exp_t e;
    rdy = 1'b0;
    inValid[d] = 1'b1;
    inBit[d]   = b;
    for (int k = 0; k < 20 && !rdy; k++) begin
      @(negedge clk);
      rdy = inReady[d];
      @(posedge clk);
      #1;
    end
    inValid[d] = 1'b0;
    checkEq($sformatf("acceptInTime%0d", d), 32'(rdy), 1);
    if (!rdy) return;
    if (modelCnt[d] != 0 && b == modelLast[d]) begin
      modelCnt[d]++;
    end else begin
      modelCnt[d]  = 1;
      modelLast[d] = b;
    end
    det = (modelCnt[d] == runLenOf[d]);
    checkEq($sformatf("runCnt%0d", d), 32'(runCnt[d]), 32'(modelCnt[d]));
    checkEq($sformatf("detValid%0d", d), 32'(detValid[d]), 32'(det));
    if (det) begin
      e.dut = d;
      e.b   = b;
      expQ.push_back(e);
      checkEq($sformatf("holdInReady%0d", d), 32'(inReady[d]), 0);
      checkEq($sformatf("holdState%0d", d), 32'(stateO[d]), 2);
      modelCnt[d] = (overlapOf[d] != 0) ? runLenOf[d] - 1 : 0;
    end
  endtask

  // Detection monitor: pop the expected entry on every output handshake
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (rst_n && detValid[d] && detReady[d]) begin
        checkEq($sformatf("detExpected%0d", d), 32'(expQ.size() != 0), 1);
        if (expQ.size() != 0) begin
          e = expQ.pop_front();
          checkEq("detDut", 32'(d), 32'(e.dut));
          checkEq($sformatf("detBit%0d", d), 32'(detBit[d]), 32'(e.b));
        end
        nAcc[d]++;
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    clear    = '0;
    inValid  = '0;
    inBit    = '0;
    detReady = '1;
    resetModel();
    #12;
    checkResetState("reset");
    rst_n = 1'b1;
    idle(1);

    // RUN_LEN=2 non-overlap: 1,1 back-to-back
    sendBit(0, 1'b1);
    sendBit(0, 1'b1);
    checkEq("s1_detBit", 32'(detBit[0]), 1);
    idle(1);
    checkEq("s1_inReady", 32'(inReady[0]), 1);
    checkEq("s1_state", 32'(stateO[0]), 0);
    checkEq("s1_runCnt", 32'(runCnt[0]), 0);
    checkEq("s1_detValid", 32'(detValid[0]), 0);
    checkEq("s1_evtA", 32'(evtA), 32'(expEvt(0, 65535)));

    // RUN_LEN=3 overlap: five zeros give three detections, then two more saturate EVT_W=2
    for (int i = 0; i < 5; i++) sendBit(1, 1'b0);
    idle(1);
    checkEq("s2_nDet", 32'(nAcc[1]), 3);
    checkEq("s2_evtB", 32'(evtB), 32'(expEvt(1, 3)));
    checkEq("s2_state", 32'(stateO[1]), 1);
    checkEq("s2_runCnt", 32'(runCnt[1]), 2);
    sendBit(1, 1'b0);
    sendBit(1, 1'b0);
    idle(1);
    checkEq("s2_nDetSat", 32'(nAcc[1]), 5);
    checkEq("s2_evtBSat", 32'(evtB), 32'(expEvt(1, 3)));

    // RUN_LEN=3: 1,1,0,1,1,0 never completes a run
    begin
      logic [5:0] pat;
      pat = 6'b011011;
      for (int i = 0; i < 6; i++) sendBit(2, pat[i]);
    end
    idle(2);
    checkEq("s3_nDet", 32'(nAcc[2]), 0);

    // Back-pressure: consumer stalls 5 cycles while a new bit is offered
    detReady[2] = 1'b0;
    for (int i = 0; i < 3; i++) sendBit(2, 1'b1);
    inValid[2] = 1'b1;
    inBit[2]   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkEq($sformatf("bp_inReady%0d", i), 32'(inReady[2]), 0);
      checkEq($sformatf("bp_detValid%0d", i), 32'(detValid[2]), 1);
      checkEq($sformatf("bp_detBit%0d", i), 32'(detBit[2]), 1);
      checkEq($sformatf("bp_runCnt%0d", i), 32'(runCnt[2]), 3);
    end
    @(posedge clk);
    #1;
    detReady[2] = 1'b1;
    sendBit(2, 1'b0);
    idle(1);
    checkEq("bp_nDet", 32'(nAcc[2]), 1);
    checkEq("bp_evtC", 32'(evtC), 32'(expEvt(2, 65535)));

    // Asynchronous reset while a detection is held
    detReady[0] = 1'b0;
    sendBit(0, 1'b0);
    sendBit(0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    checkResetState("asyncRst");
    resetModel();
    #1;
    rst_n       = 1'b1;
    detReady[0] = 1'b1;
    idle(1);
    checkEq("rst_detLost", 32'(detValid[0]), 0);
    checkEq("rst_stateIdle", 32'(stateO[0]), 0);

    // Clear together with an accept that would otherwise complete a run
    sendBit(0, 1'b1);
    sendBit(0, 1'b1);
    idle(1);
    checkEq("clr_evtBefore", 32'(evtA), 32'(expEvt(0, 65535)));
    sendBit(0, 1'b1);
    inValid[0] = 1'b1;
    inBit[0]   = 1'b1;
    clear[0]   = 1'b1;
    idle(1);
    clear[0]   = 1'b0;
    inValid[0] = 1'b0;
    checkEq("clr_state", 32'(stateO[0]), 0);
    checkEq("clr_runCnt", 32'(runCnt[0]), 0);
    checkEq("clr_detValid", 32'(detValid[0]), 0);
    checkEq("clr_detBit", 32'(detBit[0]), 0);
    checkEq("clr_inReady", 32'(inReady[0]), 1);
    checkEq("clr_evtA", 32'(evtA), 0);
    modelCnt[0]  = 0;
    modelLast[0] = 1'b0;
    sendBit(0, 1'b1);

    idle(3);
    checkEq("expQueueEmpty", 32'(expQ.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
